router_input_arbiter: RTL and testbench
=======================================

# router_input_arbiter

Round-robin input scheduler for one mesh router. Each cycle it chooses one of the `REN` input queues (core, north, east, south, west). It presents that queue's head packet to the XY routing stage, together with the queue index on `shift`. It then holds the grant until the routing stage reports the packet forwarded or a wait timeout expires. The block sits between the per-port input FIFOs and the routing logic, and decides which FIFO is popped.

## Interface
- `REN`, default 5: number of input ports/queues (0=core, 1=N, 2=E, 3=S, 4=W).
- `REN_B`, default 3: width of a port index; `2**REN_B >= REN`.
- `PL`, default `` `PL ``: packet width in bits; bit 0 is the packet-valid flag.
- `MAX_WAIT`, default 8: cycles a grant is held without forwarding before release; 0 disables the timeout.

Ports:
- `clk`, in, 1: clock, all state updates on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `queue_valid[0:REN-1]`, in, 1 each: input queue non-empty.
- `queue_head[0:REN-1]`, in, PL each: head packet of each queue.
- `shift_signals[0:REN-1]`, in, 1 each: forward/pop indication from the routing stage, one-hot on the granted index.
- `from_arbiter`, out, PL: packet presented to the routing stage; all zero when there is no grant.
- `shift`, out, REN_B: index of the granted queue.
- `timeout`, out, 1: one-cycle pulse when a grant is released by timeout.

## Operation
- Registered state:
  - `state` ∈ {SCAN, HOLD}
  - `ptr`: round-robin priority start, 0..REN-1
  - `cur`: granted index
  - `wait_cnt`: wait counter, width ≥ clog2(MAX_WAIT+1)
  - `timeout` register
- Decisions are made only in registered `state`; the packet path is combinational.
- SCAN:
  - Search indices `ptr`, `ptr+1`, …, wrapping mod REN, for the first with `queue_valid` = 1.
  - If one is found: `cur` <= that index, `wait_cnt` <= 0, next state HOLD.
  - If none is found: stay in SCAN; `ptr` and `cur` are unchanged.
- SCAN outputs: `from_arbiter` = 0; `shift` = `cur`.
- HOLD outputs:
  - `from_arbiter` = `queue_head[cur]` when `queue_valid[cur]`, else 0.
  - `shift` = `cur`.
- HOLD, priority of exits (highest first):
  1. `shift_signals[cur]` = 1: packet consumed this edge. `ptr` <= (`cur`+1) mod REN; next state SCAN.
  2. `queue_valid[cur]` = 0: next state SCAN; `ptr` unchanged.
  3. MAX_WAIT ≠ 0 and `wait_cnt` = MAX_WAIT−1: `timeout` <= 1; `ptr` <= (`cur`+1) mod REN; next state SCAN.
  4. Otherwise: `wait_cnt` <= `wait_cnt`+1; stay in HOLD.
- `shift_signals[j]` for j ≠ `cur`, and any `shift_signals` asserted in SCAN, are ignored and have no effect on state.
- Index increments wrap at REN, not at 2**REN_B; index values ≥ REN are never produced.
- `timeout` is 0 in every cycle other than the one after a timeout exit.

## Timing
- Reset values (after the first edge with `rst`=1, regardless of state or inputs):
  - `state` = SCAN
  - `ptr` = 0
  - `cur` = 0
  - `wait_cnt` = 0
  - `timeout` = 0
  - hence `from_arbiter` = 0 and `shift` = 0.
- Reset asserted mid-HOLD drops the grant; no `shift_signals` is honoured in that cycle.
- Grant latency: a queue valid at edge N (SCAN) is presented in HOLD from cycle N+1.
- Sustained throughput: one packet per 2 cycles (SCAN bubble after each consume).
- `from_arbiter` and `shift` follow `queue_head`/`queue_valid` combinationally within HOLD. The routing stage's `shift_signals` may depend on them in the same cycle; there is no combinational path from `shift_signals` to any output.
- Timeout: the grant is held for exactly MAX_WAIT HOLD cycles. `timeout` is high in the following SCAN cycle.
- Consume and timeout in the same cycle: consume wins and `timeout` stays 0.

## Test plan
- Reset: drive all queues valid and assert `rst` for 1 cycle → next cycle `from_arbiter`=0, `shift`=0, `timeout`=0, state SCAN.
- Single grant: only `queue_valid[2]`=1, head=0x…A5 (bit0=1), `shift_signals[2]`=1 in HOLD → cycle 1 SCAN, cycle 2 `shift`=2 and `from_arbiter`=head, cycle 3 SCAN with `ptr`=3.
- Fairness: all 5 queues valid, consume every HOLD → grant order 0,1,2,3,4,0,1, one grant every 2 cycles.
- Wrap: force `ptr`=4 (grant 3, then consume), `queue_valid`={0,3} → next grant 0, then 3.
- Timeout: MAX_WAIT=8, only queue 1 valid, never consumed → 8 HOLD cycles with `shift`=1, `timeout` pulse for 1 cycle, then re-grant of 1 with `wait_cnt`=0. With queue 4 also valid → 4 is granted after the timeout.
- Mid-operation: `rst` during HOLD on index 3 with `shift_signals[3]`=1 → no pointer advance, `ptr`=0; stray `shift_signals[0]` during a grant to 2 → ignored, grant held.

Source files
------------

// File: rtl/router_input_arbiter_if.sv
// router_input_arbiter_if
// Bundles the signals between the per-port input FIFOs / XY routing stage
// and the round-robin input arbiter.
//   queue_valid   : per-queue non-empty flag             (FIFO side -> arbiter)
//   queue_head    : per-queue head packet, bit 0 = valid (FIFO side -> arbiter)
//   shift_signals : per-queue forward/pop from routing   (routing   -> arbiter)
//   from_arbiter  : packet presented to routing, 0 when no grant
//   shift         : index of the granted queue
//   timeout       : one-cycle pulse after a grant is dropped by timeout
// Modports: master = FIFO/routing side, slave = arbiter.
`ifndef PL
`define PL 32
`endif

interface router_input_arbiter_if #(
    parameter int REN   = 5,
    parameter int REN_B = 3,
    parameter int PL    = `PL
);
    logic            queue_valid   [0:REN-1];
    logic [PL-1:0]   queue_head    [0:REN-1];
    logic            shift_signals [0:REN-1];
    logic [PL-1:0]   from_arbiter;
    logic [REN_B-1:0] shift;
    logic            timeout;

    modport master (
        output queue_valid, queue_head, shift_signals,
        input  from_arbiter, shift, timeout
    );

    modport slave (
        input  queue_valid, queue_head, shift_signals,
        output from_arbiter, shift, timeout
    );
endinterface

// File: rtl/router_input_arbiter.sv
// router_input_arbiter
// Round-robin input scheduler for one mesh router. In SCAN it picks the first
// non-empty queue starting at the priority pointer; in HOLD it presents that
// queue's head packet to the routing stage until the packet is forwarded, the
// queue empties, or the wait timeout expires.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   arb : router_input_arbiter_if.slave (queue status/heads, forward
//         indications in; granted packet, grant index, timeout pulse out)
`ifndef PL
`define PL 32
`endif

module router_input_arbiter #(
    parameter int REN      = 5,
    parameter int REN_B    = 3,
    parameter int PL       = `PL,
    parameter int MAX_WAIT = 8
) (
    input logic                   clk,
    input logic                   rst,
    router_input_arbiter_if.slave arb
);

    // Counter must hold 0..MAX_WAIT-1; keep at least one bit when the timeout
    // is disabled so the declaration stays legal.
    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [REN_B-1:0] LAST_IDX  = REN_B'(REN - 1);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q;
    logic [REN_B-1:0] ptr_q;
    logic [REN_B-1:0] cur_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic             timeout_q;

    logic             scan_hit_d;
    logic [REN_B-1:0] scan_idx_d;
    logic [REN_B-1:0] cand;
    logic [REN_B-1:0] ptr_after_cur_d;

    // Circular search from ptr_q; the candidate wraps at REN rather than at
    // 2**REN_B so out-of-range indices are never visited.
    always_comb begin
        scan_hit_d = 1'b0;
        scan_idx_d = '0;
        cand       = ptr_q;
        for (int k = 0; k < REN; k++) begin
            if (!scan_hit_d && arb.queue_valid[cand]) begin
                scan_hit_d = 1'b1;
                scan_idx_d = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    assign ptr_after_cur_d = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            ptr_q      <= '0;
            cur_q      <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (scan_hit_d) begin
                        cur_q      <= scan_idx_d;
                        wait_cnt_q <= '0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // Exit order: consume beats an emptied queue, which beats
                    // the timeout; a consume on the last wait cycle therefore
                    // suppresses the timeout pulse.
                    if (arb.shift_signals[cur_q]) begin
                        ptr_q   <= ptr_after_cur_d;
                        state_q <= SCAN;
                    end else if (!arb.queue_valid[cur_q]) begin
                        state_q <= SCAN;
                    end else if ((MAX_WAIT != 0) && (wait_cnt_q == WAIT_LAST)) begin
                        timeout_q <= 1'b1;
                        ptr_q     <= ptr_after_cur_d;
                        state_q   <= SCAN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    // The packet path is purely combinational from the queue heads so the
    // routing stage sees the head in the same cycle the grant is held.
    assign arb.from_arbiter = ((state_q == HOLD) && arb.queue_valid[cur_q])
                              ? arb.queue_head[cur_q] : '0;
    assign arb.shift        = cur_q;
    assign arb.timeout      = timeout_q;

endmodule

// File: tb/tb_router_input_arbiter.sv
// tb_router_input_arbiter
// Self-checking bench for router_input_arbiter: directed scenarios (reset,
// single grant, fairness, wrap, timeout, mid-operation reset, stray forward
// indications) followed by randomized traffic, all compared every cycle
// against a behavioural reference model.
module tb_router_input_arbiter;

    localparam int REN      = 5;
    localparam int REN_B    = 3;
    localparam int PL       = 32;
    localparam int MAX_WAIT = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    router_input_arbiter_if #(.REN(REN), .REN_B(REN_B), .PL(PL)) arb ();

    router_input_arbiter #(
        .REN(REN), .REN_B(REN_B), .PL(PL), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    int testCount = 0;
    int failCount = 0;

    logic [PL-1:0] headVal [REN];

    // Reference model: whether a grant is held, on which queue, the
    // round-robin start, cycles waited so far and the pending timeout pulse.
    bit mHolding;
    int mPtr;
    int mCur;
    int mWait;
    bit mTimeout;

    typedef struct packed {
        logic             g;
        logic [REN_B-1:0] s;
        logic             t;
    } trace_t;

    trace_t trace [$];
    int     grantList [$];
    int     grantCycle [$];
    bit     doCheck;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic [REN-1:0] qv, input logic [REN-1:0] ss,
                             input logic r);
        bit found;
        if (r) begin
            mHolding = 0; mPtr = 0; mCur = 0; mWait = 0; mTimeout = 0;
        end else begin
            mTimeout = 0;
            if (!mHolding) begin
                found = 0;
                for (int k = 0; k < REN; k++) begin
                    if (!found && qv[(mPtr + k) % REN]) begin
                        found    = 1;
                        mCur     = (mPtr + k) % REN;
                        mWait    = 0;
                        mHolding = 1;
                    end
                end
            end else if (ss[mCur]) begin
                mPtr     = (mCur + 1) % REN;
                mHolding = 0;
            end else if (!qv[mCur]) begin
                mHolding = 0;
            end else if (MAX_WAIT != 0 && mWait + 1 == MAX_WAIT) begin
                mTimeout = 1;
                mPtr     = (mCur + 1) % REN;
                mHolding = 0;
            end else begin
                mWait++;
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance the model for the coming rising edge.
    task automatic applyStimulus(input logic [REN-1:0] qv, input logic [REN-1:0] ss,
                                 input logic r);
        logic [PL-1:0] expFrom;
        trace_t        e;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < REN; i++) begin
            arb.queue_valid[i]   = qv[i];
            arb.shift_signals[i] = ss[i];
            arb.queue_head[i]    = headVal[i];
        end
        #1;
        expFrom = (mHolding && qv[mCur]) ? headVal[mCur] : '0;
        if (doCheck) begin
            checkOutput("from_arbiter", 64'(arb.from_arbiter), 64'(expFrom));
            checkOutput("shift", 64'(arb.shift), 64'(mCur));
            checkOutput("timeout", 64'(arb.timeout), 64'(mTimeout));
            e.g = (arb.from_arbiter != '0);
            e.s = arb.shift;
            e.t = arb.timeout;
            trace.push_back(e);
        end
        modelStep(qv, ss, r);
    endtask

    task automatic resetDut();
        applyStimulus('1, '1, 1'b1);
        trace.delete();
    endtask

    function automatic logic [REN-1:0] oneHot(input int idx);
        return REN'(1) << idx;
    endfunction

    // A grant starts wherever the presented packet goes from idle to valid.
    function automatic void collectGrants();
        grantList.delete();
        grantCycle.delete();
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i].g && (i == 0 || !trace[i-1].g)) begin
                grantList.push_back(int'(trace[i].s));
                grantCycle.push_back(i);
            end
        end
    endfunction

    initial begin
        int expFair [7];
        int cnt;
        int pick;
        logic [REN-1:0] qv;
        logic [REN-1:0] ss;

        expFair = '{0, 1, 2, 3, 4, 0, 1};
        for (int i = 0; i < REN; i++) headVal[i] = PL'($urandom) | PL'(1);
        mHolding = 0; mPtr = 0; mCur = 0; mWait = 0; mTimeout = 0;

        // Power-up: outputs are unknown until the first reset edge.
        doCheck = 0;
        applyStimulus('1, '0, 1'b1);
        doCheck = 1;

        // Fairness with every queue valid and each grant consumed at once;
        // the cycle right after reset also shows the reset state.
        resetDut();
        for (int c = 0; c < 16; c++) applyStimulus('1, oneHot(mCur), 1'b0);
        checkOutput("rst_grant", 64'(trace[0].g), 64'd0);
        checkOutput("rst_shift", 64'(trace[0].s), 64'd0);
        checkOutput("rst_timeout", 64'(trace[0].t), 64'd0);
        collectGrants();
        checkOutput("fair_count", 64'(grantList.size() >= 7), 64'd1);
        for (int k = 0; k < 7 && k < grantList.size(); k++) begin
            checkOutput("fair_order", 64'(grantList[k]), 64'(expFair[k]));
            checkOutput("fair_cycle", 64'(grantCycle[k]), 64'(1 + 2 * k));
        end

        // Single grant on queue 2, then pointer must sit at 3.
        resetDut();
        headVal[2] = 32'h1234_00A5;
        applyStimulus(5'b00100, '0, 1'b0);
        checkOutput("single_scan", 64'(arb.from_arbiter), 64'd0);
        applyStimulus(5'b00100, 5'b00100, 1'b0);
        checkOutput("single_head", 64'(arb.from_arbiter), 64'h1234_00A5);
        checkOutput("single_shift", 64'(arb.shift), 64'd2);
        applyStimulus(5'b11100, '0, 1'b0);
        checkOutput("single_bubble", 64'(arb.from_arbiter), 64'd0);
        applyStimulus(5'b11100, '0, 1'b0);
        checkOutput("single_next", 64'(arb.shift), 64'd3);

        // Wrap: grant 3 and consume so the pointer is 4, then {0,3} valid.
        resetDut();
        for (int c = 0; c < 2; c++) applyStimulus(5'b01000, oneHot(mCur), 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus(5'b01001, oneHot(mCur), 1'b0);
        collectGrants();
        checkOutput("wrap_count", 64'(grantList.size()), 64'd3);
        if (grantList.size() == 3) begin
            checkOutput("wrap_g0", 64'(grantList[0]), 64'd3);
            checkOutput("wrap_g1", 64'(grantList[1]), 64'd0);
            checkOutput("wrap_g2", 64'(grantList[2]), 64'd3);
        end

        // Timeout: queue 1 alone is never consumed, then queue 4 joins.
        resetDut();
        for (int c = 0; c < 11; c++) applyStimulus(5'b00010, '0, 1'b0);
        for (int c = 0; c < 10; c++) applyStimulus(5'b10010, '0, 1'b0);
        cnt = 0;
        for (int i = 1; i <= 8; i++) if (trace[i].g && trace[i].s == 3'd1) cnt++;
        checkOutput("to_hold_len", 64'(cnt), 64'(MAX_WAIT));
        checkOutput("to_pulse", 64'(trace[9].t), 64'd1);
        checkOutput("to_pulse_idle", 64'(trace[9].g), 64'd0);
        checkOutput("to_regrant", 64'(trace[10].g), 64'd1);
        checkOutput("to_pulse_end", 64'(trace[10].t), 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) if (trace[i].t) cnt++;
        checkOutput("to_pulses", 64'(cnt), 64'd2);
        checkOutput("to_after4", 64'({trace[19].g, trace[19].s}), 64'({1'b1, 3'd4}));

        // Reset during HOLD on 3 with its forward asserted: no pointer advance.
        resetDut();
        applyStimulus(5'b01000, '0, 1'b0);
        applyStimulus(5'b01000, 5'b01000, 1'b1);
        applyStimulus(5'b11000, '0, 1'b0);
        applyStimulus(5'b11000, '0, 1'b0);
        checkOutput("midrst_grant", 64'({trace[3].g, trace[3].s}), 64'({1'b1, 3'd3}));

        // Stray forward on queue 0 while queue 2 holds the grant.
        resetDut();
        for (int c = 0; c < 6; c++) applyStimulus(5'b00100, 5'b00001, 1'b0);
        cnt = 0;
        for (int i = 1; i <= 5; i++) if (trace[i].g && trace[i].s == 3'd2) cnt++;
        checkOutput("stray_held", 64'(cnt), 64'd5);

        // Random traffic: a lively phase, then a sticky slow-consume phase
        // that exercises timeouts and queues emptying mid-grant.
        resetDut();
        qv = '0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 300; c++) begin
                for (int i = 0; i < REN; i++) begin
                    headVal[i] = PL'($urandom) | PL'(1);
                    if (p == 0) qv[i] = ($urandom_range(0, 9) < 7);
                    else if ($urandom_range(0, 19) == 0) qv[i] = ~qv[i];
                end
                pick = $urandom_range(0, 19);
                if (pick < ((p == 0) ? 10 : 2)) ss = oneHot(mCur);
                else if (pick < 14) ss = oneHot($urandom_range(0, REN - 1));
                else ss = '0;
                applyStimulus(qv, ss, ($urandom_range(0, 59) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
